// File: rtl/mesi_bus_arbiter_if.sv
// Request/grant/operation bundle between the cores, the MESI arbiter and the cache op port.
// The master side is the arbiter; the slave side is the cores and the cache that drive it.
interface mesi_bus_arbiter_if #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CORE_W     = $clog2(NUM_CORES)
);

  logic [NUM_CORES-1:0]            req;
  logic [2*NUM_CORES-1:0]          req_type;
  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CORES-1:0]            gnt;
  logic                            op_valid;
  logic [CORE_W-1:0]               op_core;
  logic [ADDR_WIDTH-1:0]           op_addr;
  logic [1:0]                      op_type;
  logic                            op_done;
  logic                            operation_active;
  logic [NUM_CORES-1:0]            done;
  logic                            timeout_err;
  logic                            type_err;

  modport master (
    input  req, req_type, req_addr, op_done,
    output gnt, op_valid, op_core, op_addr, op_type,
           operation_active, done, timeout_err, type_err
  );

  modport slave (
    output req, req_type, req_addr, op_done,
    input  gnt, op_valid, op_core, op_addr, op_type,
           operation_active, done, timeout_err, type_err
  );

endinterface

// File: rtl/mesi_bus_arbiter.sv
// Round-robin sequencer serialising per-core MESI requests onto the single cache op port.
// Grant and op_valid follow req by one edge; requesters wait on done, which a hung cache forces after TIMEOUT.
module mesi_bus_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CORE_W     = $clog2(NUM_CORES),
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               reset,
  mesi_bus_arbiter_if.master bus
);

  localparam int         CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CORE_W-1:0]     r_core, r_rr, w_win, w_core_inc;
  logic [ADDR_WIDTH-1:0] r_addr, w_win_addr;
  logic [1:0]            r_type, w_win_type;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_first, r_rsvd, r_timeout_err, r_type_err;
  logic                  w_found, w_done_ok, w_timeout, w_complete;
  logic [NUM_CORES-1:0]  w_onehot;

  // Rotating priority: first requester at or above r_rr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(r_rr) + i) % NUM_CORES;
      if (!w_found && bus.req[idx]) begin
        w_found = 1'b1;
        w_win   = CORE_W'(idx);
      end
    end
  end

  assign w_win_addr = bus.req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_type = bus.req_type[int'(w_win)*2 +: 2];
  assign w_core_inc = (int'(r_core) == NUM_CORES - 1) ? '0 : r_core + 1'b1;

  // op_done during the issue cycle belongs to nothing; when it meets the timeout, op_done wins.
  assign w_done_ok  = !r_first && bus.op_done;
  assign w_timeout  = !w_done_ok && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_complete = w_done_ok || w_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = (w_win_type == OP_RSVD) ? S_RELEASE : S_WAIT;
      S_WAIT:    if (w_complete) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core        <= '0;
      r_rr          <= '0;
      r_addr        <= '0;
      r_type        <= '0;
      r_cnt         <= '0;
      r_first       <= 1'b0;
      r_rsvd        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_type_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_core  <= w_win;
          r_addr  <= w_win_addr;
          r_type  <= w_win_type;
          r_cnt   <= '0;
          r_first <= (w_win_type != OP_RSVD);
          r_rsvd  <= (w_win_type == OP_RSVD);
          if (w_win_type == OP_RSVD) r_type_err <= 1'b1;
        end
        S_WAIT: begin
          r_first <= 1'b0;
          if (w_complete) begin
            r_rr <= w_core_inc;
            if (w_timeout) r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: r_rsvd <= 1'b0;
        default: ;
      endcase
    end
  end

  // A reserved op keeps its grant through the RELEASE cycle that carries its done pulse.
  always_comb begin
    w_onehot             = '0;
    w_onehot[r_core]     = 1'b1;
    bus.gnt              = '0;
    bus.done             = '0;
    bus.op_valid         = 1'b0;
    bus.operation_active = 1'b0;
    case (r_state)
      S_WAIT: begin
        bus.gnt              = w_onehot;
        bus.operation_active = 1'b1;
        bus.op_valid         = r_first;
      end
      S_RELEASE: begin
        bus.done = w_onehot;
        if (r_rsvd) begin
          bus.gnt              = w_onehot;
          bus.operation_active = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.op_core     = r_core;
  assign bus.op_addr     = r_addr;
  assign bus.op_type     = r_type;
  assign bus.timeout_err = r_timeout_err;
  assign bus.type_err    = r_type_err;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed and randomized transactions for mesi_bus_arbiter, checked against a transaction-level model
// (rotating-priority winner search plus completion cycle = min(cache latency + 1, TIMEOUT)).
`timescale 1ns/1ps
module tb_mesi_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int CW = 2;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mesi_bus_arbiter_if #(.NUM_CORES(N), .ADDR_WIDTH(AW), .CORE_W(CW)) bus ();

  mesi_bus_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .CORE_W(CW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int             checks   = 0;
  int             failures = 0;
  logic [N-1:0]   m_req;
  logic [1:0]     m_type [N];
  logic [AW-1:0]  m_addr [N];
  int             m_rr;
  bit             m_to;
  bit             m_te;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req = m_req;
    for (int i = 0; i < N; i++) begin
      bus.req_type[2*i +: 2]   = m_type[i];
      bus.req_addr[i*AW +: AW] = m_addr[i];
    end
  endtask

  function automatic int model_winner();
    for (int i = 0; i < N; i++)
      if (m_req[(m_rr + i) % N]) return (m_rr + i) % N;
    return -1;
  endfunction

  // Entered at the negedge before the granting edge (state IDLE); leaves at the IDLE negedge after release.
  // The cache answers op_done in cycle 'lat' after the op_valid cycle; 'early' adds ignored pulses.
  task automatic do_txn(input int lat, input bit drop, input bit early, output int w);
    int           k;
    bit           to;
    logic [N-1:0] oh;
    w = model_winner();
    if (w < 0) $fatal(1, "FAIL bench_no_requester");
    oh    = '0;
    oh[w] = 1'b1;
    @(negedge clk);
    chk("gnt", bus.gnt, oh);
    chk("active", bus.operation_active, 1);
    if (m_type[w] == 2'b11) begin
      m_te = 1'b1;
      chk("rsvd_op_valid", bus.op_valid, 0);
      chk("rsvd_done", bus.done, oh);
      chk("rsvd_type_err", bus.type_err, m_te);
      if (drop) begin m_req[w] = 1'b0; drive(); end
      @(negedge clk);
      chk("rsvd_idle_gnt", bus.gnt, 0);
      chk("rsvd_idle_done", bus.done, 0);
      chk("rsvd_idle_active", bus.operation_active, 0);
      return;
    end
    chk("op_valid", bus.op_valid, 1);
    chk("op_core", bus.op_core, w);
    chk("op_addr", bus.op_addr, m_addr[w]);
    chk("op_type", bus.op_type, m_type[w]);
    chk("issue_done", bus.done, 0);
    k  = (lat + 1 <= TO) ? lat + 1 : TO;
    to = (lat + 1 > TO);
    bus.op_done = early;
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      chk("wait_op_valid", bus.op_valid, 0);
      if (c < k) begin
        chk("wait_gnt", bus.gnt, oh);
        chk("wait_done", bus.done, 0);
      end else begin
        chk("done_pulse", bus.done, oh);
        chk("done_gnt", bus.gnt, 0);
        chk("done_active", bus.operation_active, 0);
      end
      bus.op_done = (c == lat) || (c == k && early);
    end
    m_to = m_to | to;
    m_rr = (w + 1) % N;
    if (drop) begin m_req[w] = 1'b0; drive(); end
    @(negedge clk);
    bus.op_done = early;
    chk("idle_gnt", bus.gnt, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_active", bus.operation_active, 0);
    chk("timeout_err", bus.timeout_err, m_to);
    chk("type_err", bus.type_err, m_te);
  endtask

  initial begin
    int w;
    int lat;
    int j;
    m_rr = 0; m_to = 1'b0; m_te = 1'b0;
    m_req = '0;
    for (int i = 0; i < N; i++) begin m_type[i] = 2'b00; m_addr[i] = 32'h1000 * (i + 1); end
    bus.op_done = 1'b0;
    drive();

    // Reset state, with every core already requesting.
    m_req = 4'b1111;
    drive();
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_active", bus.operation_active, 0);
    chk("rst_op_core", bus.op_core, 0);
    chk("rst_op_addr", bus.op_addr, 0);
    chk("rst_op_type", bus.op_type, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_type_err", bus.type_err, 0);
    reset = 1'b0;

    // Contention: order 0,1,2,3 as each drops on done.
    for (int t = 0; t < 4; t++) do_txn(1 + t, 1'b1, 1'b0, w);

    // Single read from core 2, cache answers 3 cycles after op_valid; then search resumes at core 3.
    m_type[2] = 2'b00; m_addr[2] = 32'h100; m_req = 4'b0100; drive();
    do_txn(3, 1'b1, 1'b0, w);
    m_req = 4'b1010; drive();
    do_txn(2, 1'b1, 1'b1, w);
    do_txn(2, 1'b1, 1'b0, w);

    // Fairness: cores 0 and 1 keep requesting.
    m_req = 4'b0011; m_type[0] = 2'b01; m_type[1] = 2'b10; drive();
    for (int t = 0; t < 8; t++) do_txn(1 + (t % 3), 1'b0, t[0], w);
    m_req = '0; drive();
    @(negedge clk);

    // Reserved op type from core 1.
    m_type[1] = 2'b11; m_req = 4'b0010; drive();
    do_txn(1, 1'b1, 1'b0, w);
    m_type[1] = 2'b00;

    // op_done coinciding with the timeout edge: normal completion.
    m_req = 4'b0001; drive();
    do_txn(TO - 1, 1'b1, 1'b0, w);

    // Hung cache forces completion; a later write from core 3 still completes normally.
    m_req = 4'b0100; drive();
    do_txn(1000, 1'b1, 1'b0, w);
    m_type[3] = 2'b01; m_addr[3] = 32'hDEAD_BEE0; m_req = 4'b1000; drive();
    do_txn(4, 1'b1, 1'b0, w);
    m_req = 4'b0010; drive();
    do_txn(TO, 1'b1, 1'b0, w);

    // Randomized mix of requesters, types, addresses and cache latencies.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] && $urandom_range(0, 1) == 1) begin
          m_req[i]  = 1'b1;
          m_type[i] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          m_addr[i] = $urandom;
        end
      end
      if (m_req == '0) begin
        j = $urandom_range(0, N - 1);
        m_req[j] = 1'b1; m_type[j] = 2'b00; m_addr[j] = $urandom;
      end
      drive();
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 6);
      do_txn(lat, 1'b1, 1'($urandom_range(0, 1)), w);
    end
    m_req = '0; drive();
    bus.op_done = 1'b0;
    @(negedge clk);

    // Reset during WAIT: leave rr at 2 first so a stale pointer would pick core 2 over core 0.
    m_type[1] = 2'b00; m_req = 4'b0010; drive();
    do_txn(2, 1'b1, 1'b0, w);
    bus.op_done = 1'b0;
    m_to = 1'b1; m_te = 1'b1;
    m_type[2] = 2'b01; m_req = 4'b0100; drive();
    @(negedge clk);
    chk("pre_rst_gnt", bus.gnt, 4'b0100);
    chk("pre_rst_timeout_err", bus.timeout_err, m_to);
    chk("pre_rst_type_err", bus.type_err, m_te);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_gnt", bus.gnt, 0);
    chk("async_rst_active", bus.operation_active, 0);
    chk("async_rst_op_valid", bus.op_valid, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_timeout_err", bus.timeout_err, 0);
    chk("async_rst_type_err", bus.type_err, 0);
    m_req = '0; drive();
    @(negedge clk);
    reset = 1'b0;
    m_rr = 0; m_to = 1'b0; m_te = 1'b0;
    m_type[0] = 2'b00; m_addr[0] = 32'hCAFE_0000; m_req = 4'b0101; drive();
    do_txn(2, 1'b1, 1'b0, w);
    chk("post_rst_abandoned_done", bus.done, 0);
    do_txn(1, 1'b1, 1'b0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
